// File: rtl/fetch_mem_bridge.sv
// Instruction-fetch bridge: owns the fetch PC, issues one word read at a time,
// and hands each fetched word (with its PC and fault flag) to decode.
module fetch_mem_bridge #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic [31:0] pc_cur
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP, STOP} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  state_t      state;
  rsp_t        rsp;
  logic [31:0] redir_pc;
  logic        req_fire;

  assign rsp      = '{data: mem_rsp_data, err: mem_rsp_err};
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign req_fire = mem_req_valid && mem_req_ready;

  // Outputs depend on state/registers only, never on this cycle's inputs.
  assign mem_req_valid = (state == REQ);
  assign instr_valid   = (state == HOLD);
  assign mem_req_addr  = pc_cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc_cur      <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_fault <= 1'b0;
    end else if (redirect_valid && state != IDLE) begin
      // A redirect flushes everything; an accepted-but-unanswered read must
      // still be drained so its response is not mistaken for the new target.
      pc_cur <= redir_pc;
      unique case (state)
        REQ:        state <= req_fire ? DROP : REQ;
        WAIT, DROP: state <= mem_rsp_valid ? REQ : DROP;
        default:    state <= REQ;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ:  if (req_fire) state <= WAIT;
        WAIT: if (mem_rsp_valid) begin
          instr       <= rsp.data;
          instr_pc    <= pc_cur;
          instr_fault <= rsp.err;
          if (!rsp.err) pc_cur <= pc_cur + 32'd4;
          state <= HOLD;
        end
        HOLD: if (instr_ready) state <= instr_fault ? STOP : REQ;
        DROP: if (mem_rsp_valid) state <= REQ;
        STOP: state <= STOP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_bridge.sv
// Bench for fetch_mem_bridge: directed cycle table, wrap/async-reset sequence,
// and randomized traffic checked against a transaction-level fetch model.
module tb_fetch_mem_bridge;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_valid, mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic        instr_valid, instr_ready, instr_fault;
  logic [31:0] redirect_pc, mem_req_addr, mem_rsp_data, instr, instr_pc, pc_cur;

  logic        w_redirect_valid, w_mem_req_valid, w_mem_req_ready, w_mem_rsp_valid, w_mem_rsp_err;
  logic        w_instr_valid, w_instr_ready, w_instr_fault;
  logic [31:0] w_redirect_pc, w_mem_req_addr, w_mem_rsp_data, w_instr, w_instr_pc, w_pc_cur;

  fetch_mem_bridge #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_fault(instr_fault), .pc_cur(pc_cur)
  );

  fetch_mem_bridge #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_req_addr(w_mem_req_addr),
    .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_data(w_mem_rsp_data), .mem_rsp_err(w_mem_rsp_err),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_fault(w_instr_fault), .pc_cur(w_pc_cur)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rq_rdy, rv;
    logic [31:0] rdata;
    logic        rerr, irdy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr, e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rq_rdy,
                              input logic rv, input logic [31:0] rdata, input logic rerr,
                              input logic irdy, input logic e_rqv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc, input logic e_flt);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rq_rdy = rq_rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr;
    v.irdy = irdy; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_flt = e_flt;
    return v;
  endfunction

  // Memory image for the random run: data and fault are pure functions of address.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic merr(input logic [31:0] a);
    logic [31:0] h;
    h = (a >> 2) * 32'h2545_F491;
    return (h[31:28] == 4'h0);
  endfunction

  task automatic main_idle();
    redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; instr_ready = 1'b0;
  endtask

  localparam logic [31:0] IA = 32'h0001_0093, IB = 32'h0041_0093, IC = 32'hFF81_0093;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  initial begin
    main_idle();
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_mem_req_ready = 1'b0; w_mem_rsp_valid = 1'b0;
    w_mem_rsp_data = '0; w_mem_rsp_err = 1'b0; w_instr_ready = 1'b0;

    // ---- directed cycle table: sequential fetch, backpressure, redirects, fault ----
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, IA, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 4, 1, IA, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 4, 0, IA, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, IB, 0, 0, 0, 4, 0, IA, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 8, 1, IB, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 8, 1, IB, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 8, 0, IB, 4, 0));
    vecs.push_back(mk(0, 0, 1, 1, IC, 0, 1, 0, 8, 0, IB, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 12, 1, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 12, 0, IC, 8, 0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 1, 0, 12, 0, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 32'h100, 0, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'h100, 0, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 32'h100, 0, IC, 8, 0));
    vecs.push_back(mk(1, 32'h200, 1, 1, 32'h13, 0, 1, 0, 32'h100, 0, IC, 8, 0));
    vecs.push_back(mk(1, 32'h303, 0, 0, 0, 0, 1, 1, 32'h200, 0, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 32'h300, 0, IC, 8, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h13, 0, 1, 0, 32'h300, 0, IC, 8, 0));
    vecs.push_back(mk(1, 4, 1, 0, 0, 0, 1,  0, 32'h304, 1, 32'h13, 32'h300, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 4, 0, 32'h13, 32'h300, 0));
    vecs.push_back(mk(0, 0, 1, 1, BAD, 1, 1, 0, 4, 0, 32'h13, 32'h300, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 4, 1, BAD, 4, 1));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 0, 1, (i == 2), 32'h1111_1111, 0, 1, 0, 4, 0, BAD, 4, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1,  0, 4, 0, BAD, 4, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  1, 0, 0, BAD, 4, 1));
    vecs.push_back(mk(0, 0, 1, 1, IA, 0, 1, 0, 0, 0, BAD, 4, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 4, 1, IA, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 4, 0, IA, 0, 0));

    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("row%0d mem_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].e_rqv});
      chk($sformatf("row%0d mem_req_addr", i), mem_req_addr, vecs[i].e_addr);
      chk($sformatf("row%0d pc_cur", i), pc_cur, vecs[i].e_addr);
      chk($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_iv});
      chk($sformatf("row%0d instr", i), instr, vecs[i].e_instr);
      chk($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
      chk($sformatf("row%0d instr_fault", i), {31'b0, instr_fault}, {31'b0, vecs[i].e_flt});
      redirect_valid = vecs[i].rd; redirect_pc = vecs[i].rpc; mem_req_ready = vecs[i].rq_rdy;
      mem_rsp_valid = vecs[i].rv; mem_rsp_data = vecs[i].rdata; mem_rsp_err = vecs[i].rerr;
      instr_ready = vecs[i].irdy;
      @(negedge clk);
    end
    main_idle();

    // ---- PC wrap from RESET_PC=FFFF_FFFC, then async reset mid-WAIT ----
    reset = 1'b0;
    w_mem_req_ready = 1'b1; w_instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap reset addr", w_mem_req_addr, 32'hFFFF_FFFC);
    chk("wrap reset req_valid", {31'b0, w_mem_req_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("wrap first req_valid", {31'b0, w_mem_req_valid}, 32'd1);
    chk("wrap first addr", w_mem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_mem_rsp_valid = 1'b1; w_mem_rsp_data = 32'h13;
    @(negedge clk);
    w_mem_rsp_valid = 1'b0;
    chk("wrap instr_valid", {31'b0, w_instr_valid}, 32'd1);
    chk("wrap instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    chk("wrap pc_cur", w_pc_cur, 32'h0);
    @(negedge clk);
    chk("wrap second req_valid", {31'b0, w_mem_req_valid}, 32'd1);
    chk("wrap second addr", w_mem_req_addr, 32'h0);
    @(negedge clk);
    chk("wrap wait req_valid", {31'b0, w_mem_req_valid}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async req_valid", {31'b0, w_mem_req_valid}, 32'd0);
    chk("async addr", w_mem_req_addr, 32'hFFFF_FFFC);
    chk("async pc_cur", w_pc_cur, 32'hFFFF_FFFC);
    chk("async instr_valid", {31'b0, w_instr_valid}, 32'd0);
    chk("async instr", w_instr, 32'h0);
    chk("async instr_pc", w_instr_pc, 32'h0);
    chk("async instr_fault", {31'b0, w_instr_fault}, 32'd0);
    chk("async main addr", mem_req_addr, 32'h0);
    @(negedge clk);
    w_mem_rsp_valid = 1'b1; w_mem_rsp_data = 32'hDEAD_BEEF;
    reset = 1'b1;
    @(negedge clk);
    chk("late rsp req_valid", {31'b0, w_mem_req_valid}, 32'd1);
    chk("late rsp addr", w_mem_req_addr, 32'hFFFF_FFFC);
    chk("late rsp instr_valid", {31'b0, w_instr_valid}, 32'd0);
    w_mem_req_ready = 1'b0;
    @(negedge clk);
    w_mem_rsp_valid = 1'b0;
    chk("rsp in REQ ignored", {31'b0, w_instr_valid}, 32'd0);
    chk("rsp in REQ req_valid", {31'b0, w_mem_req_valid}, 32'd1);

    // ---- randomized traffic against a transaction-level fetch model ----
    begin
      logic [31:0] exp_pc, pend_addr, p_instr, p_pc;
      logic        halted, pend, hold_prev, p_flt;
      int          cnt, delivered, idle;
      reset = 1'b0;
      main_idle();
      @(negedge clk);
      reset = 1'b1;
      exp_pc = 32'h0; halted = 1'b0; pend = 1'b0; hold_prev = 1'b0; cnt = 0;
      delivered = 0; idle = 0; pend_addr = '0; p_instr = '0; p_pc = '0; p_flt = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (mem_req_valid) chk("rnd req addr", mem_req_addr, exp_pc);
        if (halted) chk("rnd halted quiet", {30'b0, mem_req_valid, instr_valid}, 32'd0);
        if (hold_prev) begin
          chk("rnd stall valid", {31'b0, instr_valid}, 32'd1);
          chk("rnd stall instr", instr, p_instr);
          chk("rnd stall pc", instr_pc, p_pc);
          chk("rnd stall fault", {31'b0, instr_fault}, {31'b0, p_flt});
        end
        if (instr_valid) begin
          chk("rnd instr_pc", instr_pc, exp_pc);
          chk("rnd instr", instr, mdata(instr_pc));
          chk("rnd instr_fault", {31'b0, instr_fault}, {31'b0, merr(instr_pc)});
        end
        if (!mem_req_valid && !instr_valid && !halted) idle++; else idle = 0;
        if (idle == 40) begin
          checks++; failures++;
          $display("FAIL rnd progress: got idle for 40 cycles expected activity at cycle %0d", cyc);
        end

        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom; mem_rsp_err = $urandom_range(0, 1);
        if (pend) begin
          if (cnt == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = mdata(pend_addr); mem_rsp_err = merr(pend_addr);
            pend = 1'b0;
          end else cnt--;
        end
        mem_req_ready  = ($urandom_range(0, 3) != 0);
        instr_ready    = ($urandom_range(0, 2) != 0);
        redirect_valid = (cyc > 0) && (($urandom_range(0, 23) == 0) ||
                                       (halted && $urandom_range(0, 5) == 0));
        case ($urandom_range(0, 3))
          0:       redirect_pc = $urandom & 32'h3FF;
          1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: redirect_pc = $urandom;
        endcase

        if (mem_req_valid && mem_req_ready) begin
          pend = 1'b1; pend_addr = mem_req_addr; cnt = $urandom_range(0, 2);
        end
        hold_prev = instr_valid && !instr_ready && !redirect_valid;
        p_instr = instr; p_pc = instr_pc; p_flt = instr_fault;
        if (redirect_valid) begin
          exp_pc = redirect_pc & 32'hFFFF_FFFC; halted = 1'b0;
        end else if (instr_valid && instr_ready) begin
          delivered++;
          if (instr_fault) halted = 1'b1; else exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
      end
      chk("rnd enough deliveries", {31'b0, delivered > 100}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_mem_bridge.md
# fetch_mem_bridge

Instruction-fetch bridge between the memory port and the decode stage of the multi-cycle `utoss_riscv` core. It owns the fetch PC, issues one word read at a time over a valid/ready request channel, and accepts variable-latency responses. It presents each fetched instruction, with its PC and a fault flag, to decode over a valid/ready channel. Redirects from branches, jumps, and traps flush any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; asserted while 0.
- `redirect_valid` in 1: load a new fetch PC this cycle.
- `redirect_pc` in 32: new PC; bits [1:0] are ignored and forced to 0.
- `mem_req_valid` out 1: read request pending.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_addr` out 32: word-aligned read address; always equals `pc_cur`.
- `mem_rsp_valid` in 1: read data valid. Arrives at least 1 cycle after acceptance; at most one response per accepted request.
- `mem_rsp_data` in 32: instruction word.
- `mem_rsp_err` in 1: access fault; qualified by `mem_rsp_valid`.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode consumes the instruction this cycle.
- `instr` out 32: instruction word.
- `instr_pc` out 32: address `instr` was fetched from.
- `instr_fault` out 1: `instr` came from an error response.
- `pc_cur` out 32: current fetch PC register.

## Operation
- States:
  - IDLE: post-reset only.
  - REQ: `mem_req_valid`=1.
  - WAIT: request accepted, awaiting response.
  - HOLD: `instr_valid`=1.
  - DROP: draining a response that will be discarded.
  - STOP: halted after a fault.
- Transitions without redirect:
  - IDLE→REQ unconditionally.
  - REQ→WAIT when `mem_req_valid && mem_req_ready`.
  - WAIT→HOLD on `mem_rsp_valid`. Capture `instr`=`mem_rsp_data`, `instr_pc`=`pc_cur`, `instr_fault`=`mem_rsp_err`. If no error, `pc_cur`+=4; on error, `pc_cur` is unchanged.
  - HOLD→REQ on `instr_ready` when `instr_fault`=0; HOLD→STOP when `instr_fault`=1.
  - DROP→REQ on `mem_rsp_valid`; the response is discarded.
  - STOP holds indefinitely.
- Redirect has priority over all other transitions in every state except IDLE. It loads `pc_cur`=`redirect_pc` and clears `instr_valid` at the same edge. Next state:
  - REQ without handshake that cycle → REQ. The address changes; this is the only permitted change of `mem_req_addr` while `mem_req_valid`=1 and unaccepted.
  - REQ with handshake that cycle → DROP.
  - WAIT without `mem_rsp_valid` → DROP.
  - WAIT with `mem_rsp_valid` → REQ; the response is discarded.
  - DROP without `mem_rsp_valid` → DROP; with `mem_rsp_valid` → REQ.
  - HOLD or STOP → REQ; the held instruction is discarded even if `instr_ready`=1.
- `mem_rsp_valid` in IDLE, REQ, HOLD or STOP is ignored.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- `instr`, `instr_pc` and `instr_fault` are held stable while `instr_valid && !instr_ready`. They keep their last values when `instr_valid`=0.
- Exactly one request is outstanding at most; `mem_req_valid` is 0 in WAIT and DROP.

## Timing
- Reset values:
  - state IDLE.
  - `pc_cur`=`mem_req_addr`=`RESET_PC`.
  - `mem_req_valid`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_fault`=0.
- Reset assertion mid-operation forces these values immediately. It does not wait for a clock edge.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- First edge after reset release enters REQ, so `mem_req_valid` rises 1 cycle after release.
- Best-case throughput with `mem_req_ready`=1 and 1-cycle response latency:
  - Request accepted in cycle N.
  - Response arrives in cycle N+1.
  - `instr_valid` is high in cycle N+2; consumed at N+2.
  - Next request in cycle N+3: 3 cycles per instruction.
- Each extra cycle of memory latency or decode backpressure adds exactly one cycle.
- Redirect to first `mem_req_valid` with the new address:
  - REQ, HOLD, STOP: next cycle.
  - WAIT or DROP: the cycle after the flushed response arrives.

## Test plan
- Sequential fetch. Setup: `RESET_PC`=0, memory [0]=32'h00010093, [1]=32'h00410093, [2]=32'hff810093, `mem_req_ready`=1, 1-cycle latency, `instr_ready`=1. Required: `instr_valid` first at cycle 3 after release; `instr_pc` 0, 4, 8 with matching words; `pc_cur`=12.
- Backpressure. Hold `instr_ready`=0 for 5 cycles on the second instruction. Required: `instr`=32'h00410093 and `instr_pc`=4 stable; no `mem_req_valid`; next request addr 8 one cycle after consume.
- Redirect during WAIT. 3-cycle latency; redirect to 32'h100 one cycle after acceptance; stale response 32'hDEADBEEF. Required: `instr_valid` never carries DEADBEEF; next request addr 32'h100 one cycle after the stale response.
- Redirect in the same cycle as a response in WAIT, to 32'h200. Required: no `instr_valid`; `mem_req_valid` with addr 32'h200 next cycle. Also: redirect to 32'h303 fetches from 32'h300.
- Fault. `mem_rsp_err`=1 at addr 4. Required: `instr_fault`=1, `instr_pc`=4, `pc_cur`=4; after consume, no `mem_req_valid` for 10 cycles; redirect to 0 resumes fetching at 0.
- Wrap and async reset. With `RESET_PC`=32'hFFFF_FFFC, the second request addr is 0. Then drive `reset` low mid-WAIT with no clock edge. Required: all outputs reach reset values immediately; a late response after release is ignored.
